// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU; latency 1 for single-cycle ops, DATA_WIDTH_P+1 for the iterative MUL.
// Backpressure: o_ready drops while MUL iterates or while an undrained result blocks the output register.
module alu_pipe #(
  parameter int DATA_WIDTH_P  = 32,
  parameter int CNTRL_WIDTH_P = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [CNTRL_WIDTH_P-1:0] i_control,
  input  logic [DATA_WIDTH_P-1:0]  i_a,
  input  logic [DATA_WIDTH_P-1:0]  i_b,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_WIDTH_P-1:0]  o_result,
  output logic                     o_zero,
  output logic                     o_overflow,
  output logic                     o_illegal
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH_P);
  localparam int CNT_W   = SHAMT_W + 1;
  localparam int MSB     = DATA_WIDTH_P - 1;
  localparam logic [CNT_W-1:0] MUL_STEPS = CNT_W'(DATA_WIDTH_P);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b1111;

  typedef logic [DATA_WIDTH_P-1:0] word_t;

  typedef struct packed {
    word_t result;
    logic  zero;
    logic  overflow;
    logic  illegal;
  } res_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   step_cnt;
  word_t              mcand;
  word_t              mplier;
  word_t              acc;

  logic [3:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               is_mul;
  logic               mul_start;
  logic               mul_done;
  logic               wr_alu;
  logic               drain;

  word_t              sum;
  word_t              diff;
  word_t              alu_res;
  logic               alu_ovf;
  logic               alu_ill;

  res_t               alu_pkt;
  res_t               mul_pkt;
  res_t               res_q;

  assign op    = i_control;
  assign shamt = i_b[SHAMT_W-1:0];
  assign sum   = i_a + i_b;
  assign diff  = i_a - i_b;

  assign accept    = i_valid && o_ready;
  assign is_mul    = (op == OP_MUL);
  assign mul_start = accept && is_mul;
  assign wr_alu    = accept && !is_mul;
  assign mul_done  = (state == ST_MUL) && (step_cnt == MUL_STEPS);
  assign drain     = o_valid && i_ready;

  // Single-cycle datapath; undefined opcodes fall through to a zero result flagged illegal.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_AND:  alu_res = i_a & i_b;
      OP_OR:   alu_res = i_a | i_b;
      OP_XOR:  alu_res = i_a ^ i_b;
      OP_NOR:  alu_res = ~(i_a | i_b);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (i_a[MSB] == i_b[MSB]) && (sum[MSB] != i_a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (i_a[MSB] != i_b[MSB]) && (diff[MSB] != i_a[MSB]);
      end
      OP_SLTU: alu_res = {{(DATA_WIDTH_P-1){1'b0}}, (i_a < i_b)};
      OP_SLT:  alu_res = {{(DATA_WIDTH_P-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLL:  alu_res = i_a << shamt;
      OP_SRL:  alu_res = i_a >> shamt;
      OP_SRA:  alu_res = word_t'($signed(i_a) >>> shamt);
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    alu_pkt          = '0;
    alu_pkt.result   = alu_res;
    alu_pkt.zero     = (alu_res == '0);
    alu_pkt.overflow = alu_ovf;
    alu_pkt.illegal  = alu_ill;
  end

  always_comb begin
    mul_pkt        = '0;
    mul_pkt.result = acc;
    mul_pkt.zero   = (acc == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mul_start) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == ST_IDLE) && (!o_valid || i_ready);
  end

  // Shift-add multiplier: the accept edge loads, then one partial-product step per cycle;
  // the cycle after the last step hands acc to the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
    end else if (state == ST_IDLE) begin
      if (mul_start) begin
        step_cnt <= '0;
        mcand    <= i_a;
        mplier   <= i_b;
        acc      <= '0;
      end
    end else if (!mul_done) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand    <= mcand << 1;
      mplier   <= mplier >> 1;
      step_cnt <= step_cnt + 1'b1;
    end else begin
      step_cnt <= '0;
    end
  end

  // MUL only starts with the output register empty or draining, so completion never collides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      res_q   <= '0;
    end else if (wr_alu || mul_done) begin
      o_valid <= 1'b1;
      res_q   <= mul_done ? mul_pkt : alu_pkt;
    end else if (drain) begin
      o_valid <= 1'b0;
    end
  end

  assign o_result   = res_q.result;
  assign o_zero     = res_q.zero;
  assign o_overflow = res_q.overflow;
  assign o_illegal  = res_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors with literal expectations plus an every-cycle reference model.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int SH = $clog2(W);
  localparam longint SMAX = (64'sd1 <<< (W-1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (W-1));

  logic         clk = 1'b0;
  logic         reset;
  logic         i_valid;
  logic         o_ready;
  logic [3:0]   i_control;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_result;
  logic         o_zero;
  logic         o_overflow;
  logic         o_illegal;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.DATA_WIDTH_P(W), .CNTRL_WIDTH_P(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_control  (i_control),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_zero     (o_zero),
    .o_overflow (o_overflow),
    .o_illegal  (o_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         v;
    logic         il;
    int           due;
    int           seq;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         v;
    logic         il;
  } vec_t;

  exp_t         q[$];
  int           cyc = 0;
  int           busy_end = 0;
  int           seq_ctr = 0;
  int           n_issued = 0;
  logic [W-1:0] got_res [64];
  logic         got_z   [64];
  logic         got_v   [64];
  logic         got_il  [64];
  bit           got_seen[64];
  int           got_cyc [64];
  int           acc_cyc [64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    longint sr;
    e = '{res: '0, z: 1'b0, v: 1'b0, il: 1'b0, due: 0, seq: 0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0011: e.res = a ^ b;
      4'b0100: e.res = ~(a | b);
      4'b0010: begin sr = sa + sb; e.res = a + b; e.v = (sr > SMAX) || (sr < SMIN); end
      4'b0110: begin sr = sa - sb; e.res = a - b; e.v = (sr > SMAX) || (sr < SMIN); end
      4'b0111: e.res = (a < b) ? 1 : 0;
      4'b1111: e.res = (sa < sb) ? 1 : 0;
      4'b1000: e.res = a << b[SH-1:0];
      4'b1001: e.res = a >> b[SH-1:0];
      4'b1010: e.res = W'(sa >>> b[SH-1:0]);
      4'b1100: e.res = a * b;
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expected results queue with due cycles, plus the MUL busy window.
  always @(negedge clk) begin
    exp_t e;
    bit   mv;
    bit   mr;
    int   s;
    if (reset) begin
      q.delete();
      busy_end = 0;
      chk("reset_o_valid", 64'(o_valid), 64'(0));
      chk("reset_o_result", 64'(o_result), 64'(0));
      chk("reset_flags", 64'({o_zero, o_overflow, o_illegal}), 64'(0));
    end else begin
      mv = (q.size() > 0) && (q[0].due <= cyc);
      mr = (cyc >= busy_end) && (!mv || i_ready);
      chk("o_valid", 64'(o_valid), 64'(mv));
      chk("o_ready", 64'(o_ready), 64'(mr));
      if (mv && o_valid) begin
        chk("o_result", 64'(o_result), 64'(q[0].res));
        chk("o_zero", 64'(o_zero), 64'(q[0].z));
        chk("o_overflow", 64'(o_overflow), 64'(q[0].v));
        chk("o_illegal", 64'(o_illegal), 64'(q[0].il));
      end
      if (mv && i_ready) begin
        s = q[0].seq;
        got_res[s]  = o_result;
        got_z[s]    = o_zero;
        got_v[s]    = o_overflow;
        got_il[s]   = o_illegal;
        got_cyc[s]  = cyc;
        got_seen[s] = 1'b1;
        void'(q.pop_front());
      end
      if (i_valid && mr) begin
        e = model(i_control, i_a, i_b);
        e.due = cyc + 1 + ((i_control == 4'b1100) ? W + 1 : 0);
        if (i_control == 4'b1100) busy_end = cyc + W + 2;
        e.seq = seq_ctr;
        acc_cyc[seq_ctr] = cyc;
        seq_ctr++;
        q.push_back(e);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call only just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int s);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    i_valid = 1'b1; i_control = op; i_a = a; i_b = b;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = o_ready;
      n++;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_accept: o_ready=0 for %0d cycles, required 1", n);
    end
    s = n_issued;
    n_issued++;
    i_valid = 1'b0;
    i_control = 4'($urandom);
    i_a = $urandom;
    i_b = $urandom;
  endtask

  task automatic lit(input string nm, input int s, input logic [W-1:0] r,
                     input logic z, input logic v, input logic il);
    int n;
    n = 0;
    while (!got_seen[s] && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!got_seen[s]) begin
      checks++;
      errors++;
      $display("FAIL %s: no result after %0d cycles, required %0h", nm, n, r);
    end else begin
      chk({nm, "_result"}, 64'(got_res[s]), 64'(r));
      chk({nm, "_zero"}, 64'(got_z[s]), 64'(z));
      chk({nm, "_overflow"}, 64'(got_v[s]), 64'(v));
      chk({nm, "_illegal"}, 64'(got_il[s]), 64'(il));
    end
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   s0;
    int   s1;
    int   s2;
    int   n;
    vec_t vt[$];
    int   sq[$];

    reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_control = '0; i_a = '0; i_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_reset", 64'(o_ready), 64'(1));
    sync();

    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, s0);
    lit("add_ovf", s0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    issue(4'b0110, 32'd5, 32'd5, s0);
    issue(4'b1111, 32'hFFFF_FFFF, 32'h1, s1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1, s2);
    lit("sub_5_5", s0, 32'h0, 1'b1, 1'b0, 1'b0);
    lit("slt_m1_1", s1, 32'h1, 1'b0, 1'b0, 1'b0);
    lit("sltu_m1_1", s2, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("b2b_gap_1", 64'(got_cyc[s1] - got_cyc[s0]), 64'(1));
    chk("b2b_gap_2", 64'(got_cyc[s2] - got_cyc[s1]), 64'(1));

    issue(4'b1010, 32'h8000_0000, 32'h24, s0);
    issue(4'b1000, 32'h1, 32'd31, s1);
    lit("sra_sign", s0, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
    lit("sll_31", s1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);

    vt.push_back('{op: 4'b0000, a: 32'hF0F0_F0F0, b: 32'h0FF0_0FF0, r: 32'h00F0_00F0, v: 1'b0, il: 1'b0});
    vt.push_back('{op: 4'b0001, a: 32'h00FF_0000, b: 32'h0000_00FF, r: 32'h00FF_00FF, v: 1'b0, il: 1'b0});
    vt.push_back('{op: 4'b0011, a: 32'h1234_5678, b: 32'hFFFF_FFFF, r: 32'hEDCB_A987, v: 1'b0, il: 1'b0});
    vt.push_back('{op: 4'b0100, a: 32'h0, b: 32'h0, r: 32'hFFFF_FFFF, v: 1'b0, il: 1'b0});
    vt.push_back('{op: 4'b1001, a: 32'h8000_0000, b: 32'h24, r: 32'h0800_0000, v: 1'b0, il: 1'b0});
    vt.push_back('{op: 4'b1010, a: 32'h7FFF_FFF0, b: 32'h4, r: 32'h07FF_FFFF, v: 1'b0, il: 1'b0});
    vt.push_back('{op: 4'b1000, a: 32'hFFFF_FFFF, b: 32'h20, r: 32'hFFFF_FFFF, v: 1'b0, il: 1'b0});
    vt.push_back('{op: 4'b0010, a: 32'h8000_0000, b: 32'h8000_0000, r: 32'h0, v: 1'b1, il: 1'b0});
    vt.push_back('{op: 4'b0010, a: 32'h1, b: 32'h2, r: 32'h3, v: 1'b0, il: 1'b0});
    vt.push_back('{op: 4'b0110, a: 32'h8000_0000, b: 32'h1, r: 32'h7FFF_FFFF, v: 1'b1, il: 1'b0});
    vt.push_back('{op: 4'b0110, a: 32'h7FFF_FFFF, b: 32'hFFFF_FFFF, r: 32'h8000_0000, v: 1'b1, il: 1'b0});
    vt.push_back('{op: 4'b1111, a: 32'h1, b: 32'hFFFF_FFFF, r: 32'h0, v: 1'b0, il: 1'b0});
    vt.push_back('{op: 4'b0111, a: 32'h1, b: 32'hFFFF_FFFF, r: 32'h1, v: 1'b0, il: 1'b0});
    vt.push_back('{op: 4'b1011, a: 32'h5, b: 32'h6, r: 32'h0, v: 1'b0, il: 1'b1});
    vt.push_back('{op: 4'b1101, a: 32'hFFFF_FFFF, b: 32'h1, r: 32'h0, v: 1'b0, il: 1'b1});
    vt.push_back('{op: 4'b1110, a: 32'h1, b: 32'h1, r: 32'h0, v: 1'b0, il: 1'b1});
    vt.push_back('{op: 4'b1100, a: 32'd1000, b: 32'd1000, r: 32'h000F_4240, v: 1'b0, il: 1'b0});
    vt.push_back('{op: 4'b1100, a: 32'h0, b: 32'hDEAD_BEEF, r: 32'h0, v: 1'b0, il: 1'b0});
    vt.push_back('{op: 4'b0001, a: 32'h0, b: 32'h0, r: 32'h0, v: 1'b0, il: 1'b0});
    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b, s0);
      sq.push_back(s0);
    end
    foreach (vt[i]) begin
      lit($sformatf("vec%0d", i), sq[i], vt[i].r, (vt[i].r == '0), vt[i].v, vt[i].il);
    end

    issue(4'b1100, 32'hFFFF_FFFF, 32'd3, s0);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (o_ready) break;
      n++;
    end
    chk("mul_ready_low_cycles", 64'(n), 64'(33));
    sync();
    lit("mul_m1_x3", s0, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);

    i_ready = 1'b0;
    issue(4'b0011, 32'hA5A5_A5A5, 32'h0F0F_0F0F, s0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_ready", 64'(o_ready), 64'(0));
      chk("hold_valid", 64'(o_valid), 64'(1));
      chk("hold_result", 64'(o_result), 64'(32'hAAAA_AAAA));
    end
    sync();
    i_ready = 1'b1;
    issue(4'b0001, 32'h00FF_0000, 32'h0000_00FF, s1);
    lit("held_xor", s0, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0);
    lit("or_with_drain", s1, 32'h00FF_00FF, 1'b0, 1'b0, 1'b0);
    chk("drain_accept_same_edge", 64'(acc_cyc[s1]), 64'(got_cyc[s0]));

    issue(4'b0101, 32'h1234, 32'h5678, s0);
    lit("illegal_0101", s0, 32'h0, 1'b1, 1'b0, 1'b1);

    issue(4'b1100, 32'd7, 32'd9, s1);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_mul_reset", 64'(o_ready), 64'(1));
    chk("valid_after_mul_reset", 64'(o_valid), 64'(0));
    repeat (40) @(negedge clk);
    chk("mul_dropped", 64'(got_seen[s1]), 64'(0));
    sync();
    issue(4'b0010, 32'd2, 32'd3, s0);
    lit("add_after_reset", s0, 32'd5, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
